// File: rtl/kronos_trace_tx.sv
// Retirement-trace transmitter: taps EX->WB, buffers records, serializes each into a byte packet.
// Define KRONOS_TRACE_RESULT2_EN to store and send result2 (14-byte packets instead of 10).
package kronos_trace_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result1;
        logic [31:0] result2;
        logic [4:0]  rd;
        logic        rd_write;
        logic [2:0]  funct3;
        logic        branch;
        logic        ld;
        logic        st;
        logic        csr;
        logic        is_illegal;
        logic        ecall;
        logic        ebreak;
        logic        ret;
        logic        wfi;
    } pipeEXWB_t;
endpackage

module kronos_trace_tx
    import kronos_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trace_en,
    input  pipeEXWB_t  execute,
    input  logic       execute_vld,
    input  logic       execute_rdy,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    input  logic       tx_rdy,
    output logic [7:0] drop_count
);

`ifdef KRONOS_TRACE_RESULT2_EN
    localparam int NB = 14;
`else
    localparam int NB = 10;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int PW = NB * 8;
    localparam int EW = PW - 1;      // entry is the packet minus the ovf bit
    localparam int BW = $clog2(NB);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic [7:0]       tx_data_q;
    logic             tx_vld_q;
    logic [PW-9:0]    sh_q;
    logic [BW-1:0]    byte_idx_q;

    logic             cap, empty, full, accept, last, pop, push, drop;
    logic [EW-1:0]    cap_ent, head_ent;
    logic [PW-1:0]    head_pkt;

    // Entry packs B0[6:0] in the low bits, then B1 and the little-endian words
`ifdef KRONOS_TRACE_RESULT2_EN
    assign cap_ent = {execute.result2, execute.result1, execute.pc, execute.funct3, execute.rd,
                      execute.rd_write, execute.branch, execute.ld, execute.st, execute.csr,
                      execute.is_illegal,
                      execute.ecall | execute.ebreak | execute.ret | execute.wfi};
`else
    logic unused_result2;
    assign unused_result2 = ^execute.result2;
    assign cap_ent = {execute.result1, execute.pc, execute.funct3, execute.rd,
                      execute.rd_write, execute.branch, execute.ld, execute.st, execute.csr,
                      execute.is_illegal,
                      execute.ecall | execute.ebreak | execute.ret | execute.wfi};
`endif

    assign cap      = trace_en & execute_vld & execute_rdy;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign accept   = tx_vld_q & tx_rdy;
    assign last     = (byte_idx_q == BW'(NB - 1));
    assign pop      = !empty && ((state_q == IDLE) || (accept && last));
    assign push     = cap && (!full || pop);
    assign drop     = cap && full && !pop;
    assign head_ent = mem_q[rptr_q[AW-1:0]];
    assign head_pkt = {head_ent[EW-1:7], ovf_q, head_ent[6:0]};

    always_comb begin
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (pop) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= cap_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // A load on the last accepted byte keeps tx_vld high: packets go out back-to-back
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_vld_q   <= 1'b0;
            tx_data_q  <= '0;
            sh_q       <= '0;
            byte_idx_q <= '0;
        end else if (pop) begin
            state_q    <= SEND;
            tx_vld_q   <= 1'b1;
            tx_data_q  <= head_pkt[7:0];
            sh_q       <= head_pkt[PW-1:8];
            byte_idx_q <= '0;
        end else if (accept) begin
            if (last) begin
                state_q  <= IDLE;
                tx_vld_q <= 1'b0;
            end else begin
                tx_data_q  <= sh_q[7:0];
                sh_q       <= sh_q >> 8;
                byte_idx_q <= byte_idx_q + BW'(1);
            end
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_vld     = tx_vld_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_kronos_trace_tx.sv
// Bench for kronos_trace_tx: directed scenarios plus random traffic against a record-level model.
module tb_kronos_trace_tx;
    import kronos_trace_pkg::*;

`ifdef KRONOS_TRACE_RESULT2_EN
    localparam int NB = 14;
`else
    localparam int NB = 10;
`endif
    localparam int DEPTH = 4;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trace_en = 1'b0;
    pipeEXWB_t  execute = '0;
    logic       execute_vld = 1'b0;
    logic       execute_rdy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy = 1'b0;
    logic [7:0] drop_count;

    kronos_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .execute(execute),
        .execute_vld(execute_vld), .execute_rdy(execute_rdy),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: records waiting, bytes of the packet on the wire, ovf flag, drops
    pipeEXWB_t  m_fifo [$];
    logic [7:0] m_cur [$];
    logic       m_ovf = 1'b0;
    int         m_drops = 0;
    bit         m_rst_seen = 1'b0;

    logic [7:0] got [$];
    int         vrun = 0;
    int         maxrun = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bq_t mk(input pipeEXWB_t e, input logic ovf);
        bq_t b;
        b.push_back({ovf, e.rd_write, e.branch, e.ld, e.st, e.csr, e.is_illegal,
                     e.ecall | e.ebreak | e.ret | e.wfi});
        b.push_back({e.funct3, e.rd});
        for (int i = 0; i < 4; i++) b.push_back(e.pc[8*i +: 8]);
        for (int i = 0; i < 4; i++) b.push_back(e.result1[8*i +: 8]);
`ifdef KRONOS_TRACE_RESULT2_EN
        for (int i = 0; i < 4; i++) b.push_back(e.result2[8*i +: 8]);
`endif
        return b;
    endfunction

    function automatic pipeEXWB_t rnd_rec();
        pipeEXWB_t e;
        e.pc = $urandom; e.result1 = $urandom; e.result2 = $urandom;
        e.rd = 5'($urandom); e.funct3 = 3'($urandom);
        e.rd_write = 1'($urandom); e.branch = 1'($urandom); e.ld = 1'($urandom);
        e.st = 1'($urandom); e.csr = 1'($urandom); e.is_illegal = 1'($urandom);
        e.ecall = 1'($urandom); e.ebreak = 1'($urandom); e.ret = 1'($urandom);
        e.wfi = 1'($urandom);
        return e;
    endfunction

    // One cycle: check outputs at the falling edge, drive inputs, advance the model
    task automatic step(input bit en, input bit v, input bit er, input bit rdy, input bit r,
                        input pipeEXWB_t rec);
        bit cap, acc, pop, drop;
        bq_t pkt;
        @(negedge clk);
        chk("tx_vld", tx_vld, m_cur.size() > 0);
        if (m_cur.size() > 0) chk("tx_data", tx_data, m_cur[0]);
        if (m_rst_seen) chk("tx_data_rst", tx_data, 0);
        chk("drop_count", drop_count, m_drops);
        vrun   = tx_vld ? vrun + 1 : 0;
        maxrun = (vrun > maxrun) ? vrun : maxrun;
        if (tx_vld && rdy && !r) got.push_back(tx_data);

        trace_en = en; execute_vld = v; execute_rdy = er; tx_rdy = rdy; rst = r;
        execute = rec;

        m_rst_seen = r;
        if (r) begin
            m_fifo.delete(); m_cur.delete(); m_ovf = 1'b0; m_drops = 0;
        end else begin
            cap  = en && v && er;
            acc  = (m_cur.size() > 0) && rdy;
            pop  = (m_fifo.size() > 0) && ((m_cur.size() == 0) || (acc && m_cur.size() == 1));
            drop = cap && (m_fifo.size() == DEPTH) && !pop;
            if (pop) begin
                pkt   = mk(m_fifo.pop_front(), m_ovf);
                m_cur = pkt;
                m_ovf = 1'b0;
            end else if (acc) begin
                void'(m_cur.pop_front());
            end
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end else if (cap) begin
                m_fifo.push_back(rec);
            end
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, 1'b0, 1'b1, rdy, 1'b0, rnd_rec());
    endtask

    task automatic drain(input bit toggle);
        int i;
        for (i = 0; i < 500 && (m_cur.size() > 0 || m_fifo.size() > 0); i++)
            idle(toggle ? 1'(i) : 1'b1);
        if (i >= 500) chk("drain_timeout", 1, 0);
        idle(1'b1);
    endtask

    pipeEXWB_t  rec1;
    logic [7:0] exp1 [10];

    initial begin
        exp1 = '{8'h40, 8'h05, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        rec1 = '0;
        rec1.pc = 32'h0000_0100; rec1.result1 = 32'hDEAD_BEEF; rec1.result2 = 32'h1234_5678;
        rec1.rd = 5'd5; rec1.rd_write = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_vld", tx_vld, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_drop", drop_count, 0);

        // Single capture: idle at N+1, first byte valid at N+2
        got.delete();
        step(1, 1, 1, 1, 0, rec1);
        idle(1'b1);
        chk("t1_lat_n1", tx_vld, 0);
        idle(1'b1);
        chk("t1_lat_n2", tx_vld, 1);
        drain(1'b0);
        chk("t1_len", got.size(), NB);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("t1_byte", got[i], exp1[i]);

        // Back-pressure toggling every cycle
        got.delete();
        step(1, 1, 1, 1, 0, rec1);
        drain(1'b1);
        chk("t2_len", got.size(), NB);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("t2_byte", got[i], exp1[i]);

        // Overflow: first record goes in flight, next four fill the FIFO, last two drop
        got.delete();
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 0, rnd_rec());
        idle(1'b0);
        chk("t3_drops", drop_count, 2);
        drain(1'b0);
        chk("t3_len", got.size(), 5 * NB);
        for (int k = 0; k < 5 && k * NB < got.size(); k++)
            chk("t3_ovf", got[k*NB][7], k == 1);

        // Back-to-back packets with no bubble
        got.delete();
        maxrun = 0;
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, rnd_rec());
        drain(1'b0);
        chk("t4_len", got.size(), 3 * NB);
        chk("t4_run", maxrun, 3 * NB);

        // Reset after the third byte, then a fresh packet
        got.delete();
        step(1, 1, 1, 1, 0, rnd_rec());
        for (int i = 0; i < 20 && got.size() < 3; i++) idle(1'b1);
        step(1, 0, 1, 1, 1, rnd_rec());
        idle(1'b1);
        chk("t5_vld", tx_vld, 0);
        chk("t5_drop", drop_count, 0);
        got.delete();
        step(1, 1, 1, 1, 0, rec1);
        drain(1'b0);
        chk("t5_len", got.size(), NB);
        if (got.size() > 0) chk("t5_b0", got[0], 8'h40);

        // Capture disabled: nothing goes out
        got.delete();
        step(0, 1, 1, 1, 0, rec1);
        drain(1'b0);
        chk("t6_none", got.size(), 0);
`ifdef KRONOS_TRACE_RESULT2_EN
        got.delete();
        step(1, 1, 1, 1, 0, rec1);
        drain(1'b0);
        chk("t6_len", got.size(), 14);
        if (got.size() == 14) begin
            chk("t6_b10", got[10], 8'h78); chk("t6_b11", got[11], 8'h56);
            chk("t6_b12", got[12], 8'h34); chk("t6_b13", got[13], 8'h12);
        end
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++)
            step(($urandom % 8) != 0, 1'($urandom), ($urandom % 4) != 0,
                 ($urandom % 3) != 0, ($urandom % 300) == 0, rnd_rec());
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
